// File: rtl/line_client.sv
// -----------------------------------------------------------------------------
// line_client
// Read-modify-write client for a shared memory port. A local command (READ,
// WRITE, SET bits, CLR bits) is latched on start, the arbiter is asked for the
// port, the line is read and/or written while the grant is held, and the port
// is handed back before completion is reported.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       one-cycle command strobe (ignored while busy)
//   op          00 READ, 01 WRITE, 10 SET (line | wdata), 11 CLR (line & ~wdata)
//   wdata       write data or bit mask
//   gnt         grant from the arbiter
//   read_line   line data from memory, valid while gnt=1
//   req         request to the arbiter (registered)
//   we          one-cycle write strobe to memory
//   write_line  data presented with we; holds its last written value otherwise
//   rdata       last line captured by READ/SET/CLR
//   busy        high whenever the client is not idle
//   done        one-cycle completion pulse
//   err         one-cycle pulse with done on timeout or lost grant
// -----------------------------------------------------------------------------
module line_client #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [65:0] wdata,
    input  logic        gnt,
    input  logic [65:0] read_line,
    output logic        req,
    output logic        we,
    output logic [65:0] write_line,
    output logic [65:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_WR,
        S_REL
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  op_q;
    logic [65:0] wdata_q;
    logic [65:0] wr_data;    // line to be written in the WR cycle
    logic [65:0] wl_hold;    // last line actually written
    logic [7:0]  wait_cnt;
    logic        lost;       // grant was lost during RD or WR
    logic        timeout_hit;

    // The TIMEOUT-th cycle in WAIT_GNT without a grant aborts the command.
    assign timeout_hit = (state == S_WAIT) && !gnt && (wait_cnt >= TO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_WAIT;
            S_WAIT: begin
                if (gnt)              state_nx = (op_q == OP_WRITE) ? S_WR : S_RD;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_RD: begin
                if (!gnt || op_q == OP_READ) state_nx = S_REL;
                else                         state_nx = S_WR;
            end
            S_WR:    state_nx = S_REL;
            S_REL:   if (!gnt) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs. we is gated by gnt so a grant lost in WR never writes, and it
    // falls with the state register on an asynchronous reset.
    always_comb begin
        busy       = (state != S_IDLE);
        we         = (state == S_WR) && gnt;
        done       = ((state == S_REL) && !gnt) || timeout_hit;
        err        = ((state == S_REL) && !gnt && lost) || timeout_hit;
        write_line = we ? wr_data : wl_hold;
    end

    // Datapath and registered request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req      <= 1'b0;
            op_q     <= 2'b00;
            wdata_q  <= '0;
            wr_data  <= '0;
            wl_hold  <= '0;
            rdata    <= '0;
            wait_cnt <= '0;
            lost     <= 1'b0;
        end else begin
            req <= (state_nx == S_WAIT) || (state_nx == S_RD) || (state_nx == S_WR);

            if (state == S_IDLE && start) begin
                op_q    <= op;
                wdata_q <= wdata;
                lost    <= 1'b0;
            end

            // Counter is zero on every entry to WAIT_GNT and saturates at 255.
            if (state != S_WAIT)        wait_cnt <= '0;
            else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;

            if ((state == S_RD || state == S_WR) && !gnt) lost <= 1'b1;

            if (state == S_WAIT && gnt && op_q == OP_WRITE) wr_data <= wdata_q;

            if (state == S_RD && gnt) begin
                rdata <= read_line;
                // Modified line is built from the same value being captured.
                if (op_q == OP_SET) wr_data <= read_line | wdata_q;
                else                wr_data <= read_line & ~wdata_q;
            end

            if (we) wl_hold <= wr_data;
        end
    end

endmodule

// File: tb/tb_line_client.sv
module tb_line_client;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [65:0] wdata = '0;
    logic        gnt = 1'b0;
    logic [65:0] read_line = '0;
    logic        req, we, busy, done, err;
    logic [65:0] write_line, rdata;

    line_client #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .wdata(wdata),
        .gnt(gnt), .read_line(read_line), .req(req), .we(we),
        .write_line(write_line), .rdata(rdata), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [65:0] rdata;
        int          cyc;
    } done_t;

    done_t       dq[$];
    logic [65:0] wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [65:0] m_rdata = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        if (reset) begin
            if (we) begin
                if (wq.size() == 0) chk("unexpected_we", 66'(we), 66'(0));
                else chk("write_line", write_line, wq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 66'(done), 66'(0));
                else begin
                    done_t e;
                    e = dq.pop_front();
                    chk("err", 66'(err), 66'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("done_cycle", 66'(cyc), 66'(e.cyc));
                    chk("busy_at_done", 66'(busy), 66'(1));
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (busy) chk("idle_timeout", 66'(busy), 66'(0));
    endtask

    // mode 0: normal, 1: no grant (timeout), 2: grant lost in RD
    // junk: pulse start while busy and again in the done cycle (both ignored)
    task automatic run_txn(input logic [1:0] o, input logic [65:0] wd,
                           input logic [65:0] line, input int d,
                           input int mode, input bit junk);
        done_t e;
        int    lat;
        int    n;
        e.err = (mode != 0);
        if (mode == 0) begin
            lat = (o[1] ? 4 : 3) + d;
            if (o != 2'b01) m_rdata = line;
            case (o)
                2'b01:   wq.push_back(wd);
                2'b10:   wq.push_back(line | wd);
                2'b11:   wq.push_back(line & ~wd);
                default: ;
            endcase
        end else if (mode == 1) lat = TIMEOUT;
        else lat = d + 3;
        e.rdata = m_rdata;
        e.cyc   = cyc + lat;
        dq.push_back(e);

        start = 1'b1; op = o; wdata = wd; read_line = line;
        @(posedge clk); #1;
        start = junk;
        op    = 2'($urandom);
        wdata = {2'($urandom), $urandom, $urandom};
        if (mode == 1) begin
            wait_idle(TIMEOUT + 20);
            return;
        end
        repeat (d) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        gnt = 1'b1;
        if (mode == 2) begin
            @(posedge clk); #1;
            start = 1'b0;
            gnt   = 1'b0;
            wait_idle(20);
            return;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (req && n < 10);
        if (req) chk("req_release", 66'(req), 66'(0));
        gnt   = 1'b0;
        start = junk;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(20);
    endtask

    initial begin
        int mode;
        logic [1:0] o;

        #12;
        chk("rst_req", 66'(req), 66'(0));
        chk("rst_we", 66'(we), 66'(0));
        chk("rst_busy", 66'(busy), 66'(0));
        chk("rst_done", 66'(done), 66'(0));
        chk("rst_err", 66'(err), 66'(0));
        chk("rst_rdata", rdata, 66'(0));
        chk("rst_write_line", write_line, 66'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed cases
        run_txn(2'b00, 66'h0, 66'h2_DEAD_BEEF_0123_4567, 0, 0, 1'b0);
        run_txn(2'b01, 66'h3_0000_0000_0000_00FF, 66'h0, 0, 0, 1'b0);
        run_txn(2'b10, 66'hF0, 66'h0F, 0, 0, 1'b0);
        chk("set_rdata", rdata, 66'h0F);
        run_txn(2'b11, 66'h03, 66'h0F, 0, 0, 1'b0);
        chk("write_line_hold", write_line, 66'h0C);
        run_txn(2'b01, 66'h5, 66'h0, 0, 1, 1'b0);
        run_txn(2'b10, 66'hFF, 66'h1234, 1, 2, 1'b0);

        // Reset during WR
        start = 1'b1; op = 2'b01; wdata = 66'h1_1111;
        @(posedge clk); #1;
        start = 1'b0; gnt = 1'b1;
        @(posedge clk); #1;
        chk("we_in_wr", 66'(we), 66'(1));
        reset = 1'b0;
        #1;
        chk("async_req", 66'(req), 66'(0));
        chk("async_we", 66'(we), 66'(0));
        chk("async_busy", 66'(busy), 66'(0));
        chk("async_done", 66'(done), 66'(0));
        gnt = 1'b0;
        m_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("post_rst_rdata", rdata, 66'(0));
        chk("post_rst_write_line", write_line, 66'(0));

        // Randomized traffic, first command right after reset release
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            mode = 0;
            if ($urandom_range(0, 7) == 0) mode = 1;
            else if (o != 2'b01 && $urandom_range(0, 7) == 0) mode = 2;
            run_txn(o, {2'($urandom), $urandom, $urandom},
                    {2'($urandom), $urandom, $urandom},
                    $urandom_range(0, 3), mode, 1'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("done_queue_empty", 66'(dq.size()), 66'(0));
        chk("we_queue_empty", 66'(wq.size()), 66'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
